// File: rtl/rf_pkg.sv
//==============================================================================
// Module : rf_pkg
// Brief  : Shared register-file constants and a clog2 helper for ID/WB stages.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package rf_pkg;

  function automatic int rf_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = rf_clog2(NREGS_DEF);
  localparam int XZR_IDX   = NREGS_DEF - 1;

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
//==============================================================================
// Module : rf_scoreboard
// Brief  : Per-register busy bits and per-read-port RAW hazard detection.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  localparam int AW   = rf_clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_issue_en,
  input  logic [AW-1:0]     i_issue_reg,
  input  logic              i_wr_en0,
  input  logic [AW-1:0]     i_wr_addr0,
  input  logic              i_wr_en1,
  input  logic [AW-1:0]     i_wr_addr1,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD-1:0]    o_hazard
);

  localparam logic [AW-1:0] c_XZR = AW'(NREGS - 1);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Set is applied after clear so a new producer wins over a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < NREGS; r++) begin
      if ((i_wr_en0 && i_wr_addr0 == AW'(r)) || (i_wr_en1 && i_wr_addr1 == AW'(r)))
        w_busy_nxt[r] = 1'b0;
      if (i_issue_en && i_issue_reg == AW'(r) && AW'(r) != c_XZR)
        w_busy_nxt[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_haz
    logic [AW-1:0] w_addr;
    logic          w_byp;
    assign w_addr      = i_rd_addr[k*AW +: AW];
    assign w_byp       = (i_wr_en0 && i_wr_addr0 == w_addr) || (i_wr_en1 && i_wr_addr1 == w_addr);
    assign o_hazard[k] = r_busy[w_addr] && !w_byp;
  end

endmodule

`default_nettype wire

// File: rtl/rf_multiport.sv
//==============================================================================
// Module : rf_multiport
// Brief  : Multi-read, dual-write integer register file with bypass, XZR and stall.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rf_multiport
  import rf_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int NRD     = 2,
  parameter int DBG_REG = 20,
  localparam int AW     = rf_clog2(NREGS)
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [NRD*AW-1:0]   RdAddr,
  output logic [NRD*XLEN-1:0] RdData,
  input  logic                WrEn0,
  input  logic [AW-1:0]       WrAddr0,
  input  logic [XLEN-1:0]     WrData0,
  input  logic                WrEn1,
  input  logic [AW-1:0]       WrAddr1,
  input  logic [XLEN-1:0]     WrData1,
  input  logic                IssueEn,
  input  logic [AW-1:0]       IssueReg,
  output logic                Stall,
  output logic [XLEN-1:0]     DbgData
);

  localparam logic [AW-1:0] c_XZR = AW'(NREGS - 1);

  logic [XLEN-1:0] r_mem [NREGS];
  logic [NRD-1:0]  w_hazard;

  // Port 1 is written last so it wins a same-register collision.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      if (WrEn0 && WrAddr0 != c_XZR) r_mem[WrAddr0] <= WrData0;
      if (WrEn1 && WrAddr1 != c_XZR) r_mem[WrAddr1] <= WrData1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr = RdAddr[k*AW +: AW];
    assign RdData[k*XLEN +: XLEN] =
        (!Reset || w_addr == c_XZR)      ? '0      :
        (WrEn1 && WrAddr1 == w_addr)     ? WrData1 :
        (WrEn0 && WrAddr0 == w_addr)     ? WrData0 :
                                           r_mem[w_addr];
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_sb (
    .clk         (clk),
    .rst_n       (Reset),
    .i_issue_en  (IssueEn),
    .i_issue_reg (IssueReg),
    .i_wr_en0    (WrEn0),
    .i_wr_addr0  (WrAddr0),
    .i_wr_en1    (WrEn1),
    .i_wr_addr1  (WrAddr1),
    .i_rd_addr   (RdAddr),
    .o_hazard    (w_hazard)
  );

  assign Stall   = Reset && (|w_hazard);
  assign DbgData = r_mem[DBG_REG];

endmodule

`default_nettype wire

// File: tb/tb_rf_multiport.sv
//==============================================================================
// Module : tb_rf_multiport
// Brief  : Directed self-checking bench for rf_multiport.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_rf_multiport;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                Reset = 1'b1;
  logic [NRD*AW-1:0]   RdAddr = '0;
  logic [NRD*XLEN-1:0] RdData;
  logic                WrEn0 = 1'b0;
  logic [AW-1:0]       WrAddr0 = '0;
  logic [XLEN-1:0]     WrData0 = '0;
  logic                WrEn1 = 1'b0;
  logic [AW-1:0]       WrAddr1 = '0;
  logic [XLEN-1:0]     WrData1 = '0;
  logic                IssueEn = 1'b0;
  logic [AW-1:0]       IssueReg = '0;
  logic                Stall;
  logic [XLEN-1:0]     DbgData;

  int nvec = 0;
  int nerr = 0;

  rf_multiport #(.XLEN(XLEN), .NREGS(32), .NRD(NRD), .DBG_REG(20)) dut (
    .clk(clk), .Reset(Reset), .RdAddr(RdAddr), .RdData(RdData),
    .WrEn0(WrEn0), .WrAddr0(WrAddr0), .WrData0(WrData0),
    .WrEn1(WrEn1), .WrAddr1(WrAddr1), .WrData1(WrData1),
    .IssueEn(IssueEn), .IssueReg(IssueReg), .Stall(Stall), .DbgData(DbgData)
  );

  always #5 clk = ~clk;

  wire [XLEN-1:0] rd0 = RdData[0 +: XLEN];
  wire [XLEN-1:0] rd1 = RdData[XLEN +: XLEN];

  task automatic idle();
    WrEn0 = 1'b0; WrEn1 = 1'b0; IssueEn = 1'b0;
  endtask

  task automatic test_reset();
    #1 Reset = 1'b0;
    RdAddr = {5'd20, 5'd3};
    #2;
    nvec++; if (rd0 !== 64'd0) begin nerr++; $display("FAIL reset_rd0: got %h expected %h", rd0, 64'd0); end
    nvec++; if (DbgData !== 64'd0) begin nerr++; $display("FAIL reset_dbg: got %h expected %h", DbgData, 64'd0); end
    nvec++; if (Stall !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b expected 0", Stall); end
    @(negedge clk) Reset = 1'b1;
    #1;
    nvec++; if (rd1 !== 64'd0) begin nerr++; $display("FAIL reset_rd1_after: got %h expected %h", rd1, 64'd0); end
  endtask

  task automatic test_write_bypass();
    @(negedge clk);
    WrEn0 = 1'b1; WrAddr0 = 5'd3; WrData0 = 64'd4; RdAddr = {5'd0, 5'd3};
    #1;
    nvec++; if (rd0 !== 64'd4) begin nerr++; $display("FAIL bypass0: got %h expected %h", rd0, 64'd4); end
    @(negedge clk) idle();
    #1;
    nvec++; if (rd0 !== 64'd4) begin nerr++; $display("FAIL stored0: got %h expected %h", rd0, 64'd4); end
    nvec++; if (Stall !== 1'b0) begin nerr++; $display("FAIL bypass_stall: got %b expected 0", Stall); end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    WrEn0 = 1'b1; WrAddr0 = 5'd5; WrData0 = 64'h11;
    WrEn1 = 1'b1; WrAddr1 = 5'd5; WrData1 = 64'h22;
    RdAddr = {5'd0, 5'd5};
    #1;
    nvec++; if (rd0 !== 64'h22) begin nerr++; $display("FAIL dual_bypass: got %h expected %h", rd0, 64'h22); end
    @(negedge clk) idle();
    #1;
    nvec++; if (rd0 !== 64'h22) begin nerr++; $display("FAIL dual_stored: got %h expected %h", rd0, 64'h22); end
  endtask

  task automatic test_xzr();
    @(negedge clk);
    WrEn0 = 1'b1; WrAddr0 = 5'd31; WrData0 = 64'hFFFF; RdAddr = {5'd31, 5'd3};
    #1;
    nvec++; if (rd1 !== 64'd0) begin nerr++; $display("FAIL xzr_bypass: got %h expected %h", rd1, 64'd0); end
    @(negedge clk) idle();
    IssueEn = 1'b1; IssueReg = 5'd31; RdAddr = {5'd31, 5'd31};
    #1;
    nvec++; if (rd1 !== 64'd0) begin nerr++; $display("FAIL xzr_stored: got %h expected %h", rd1, 64'd0); end
    @(negedge clk) idle();
    #1;
    nvec++; if (Stall !== 1'b0) begin nerr++; $display("FAIL xzr_stall: got %b expected 0", Stall); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    IssueEn = 1'b1; IssueReg = 5'd7; RdAddr = {5'd3, 5'd7};
    #1;
    nvec++; if (Stall !== 1'b0) begin nerr++; $display("FAIL sb_pre_issue: got %b expected 0", Stall); end
    @(negedge clk) idle();
    #1;
    nvec++; if (Stall !== 1'b1) begin nerr++; $display("FAIL sb_busy: got %b expected 1", Stall); end
    WrEn1 = 1'b1; WrAddr1 = 5'd7; WrData1 = 64'h5;
    #1;
    nvec++; if (Stall !== 1'b0) begin nerr++; $display("FAIL sb_bypass_stall: got %b expected 0", Stall); end
    nvec++; if (rd0 !== 64'h5) begin nerr++; $display("FAIL sb_bypass_data: got %h expected %h", rd0, 64'h5); end
    @(negedge clk) idle();
    #1;
    nvec++; if (Stall !== 1'b0) begin nerr++; $display("FAIL sb_cleared: got %b expected 0", Stall); end
    nvec++; if (rd0 !== 64'h5) begin nerr++; $display("FAIL sb_stored: got %h expected %h", rd0, 64'h5); end
  endtask

  task automatic test_set_wins_dbg();
    @(negedge clk);
    IssueEn = 1'b1; IssueReg = 5'd8;
    WrEn0 = 1'b1; WrAddr0 = 5'd8; WrData0 = 64'h33; RdAddr = {5'd20, 5'd8};
    @(negedge clk) idle();
    #1;
    nvec++; if (Stall !== 1'b1) begin nerr++; $display("FAIL set_wins: got %b expected 1", Stall); end
    nvec++; if (rd0 !== 64'h33) begin nerr++; $display("FAIL set_wins_data: got %h expected %h", rd0, 64'h33); end
    WrEn0 = 1'b1; WrAddr0 = 5'd20; WrData0 = 64'hAB;
    #1;
    nvec++; if (DbgData !== 64'd0) begin nerr++; $display("FAIL dbg_before_edge: got %h expected %h", DbgData, 64'd0); end
    nvec++; if (rd1 !== 64'hAB) begin nerr++; $display("FAIL dbg_port_bypass: got %h expected %h", rd1, 64'hAB); end
    @(posedge clk) #1;
    nvec++; if (DbgData !== 64'hAB) begin nerr++; $display("FAIL dbg_after_edge: got %h expected %h", DbgData, 64'hAB); end
    @(negedge clk) idle();
    WrEn1 = 1'b1; WrAddr1 = 5'd8; WrData1 = 64'h0;
    @(negedge clk) idle();
    #1;
    nvec++; if (Stall !== 1'b0) begin nerr++; $display("FAIL x8_retired: got %b expected 0", Stall); end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    WrEn0 = 1'b1; WrAddr0 = 5'd3; WrData0 = 64'd4;
    WrEn1 = 1'b1; WrAddr1 = 5'd20; WrData1 = 64'd9;
    IssueEn = 1'b1; IssueReg = 5'd3;
    @(negedge clk) idle();
    RdAddr = {5'd20, 5'd3};
    #1;
    nvec++; if (Stall !== 1'b1) begin nerr++; $display("FAIL mid_pre_stall: got %b expected 1", Stall); end
    nvec++; if (DbgData !== 64'd9) begin nerr++; $display("FAIL mid_pre_dbg: got %h expected %h", DbgData, 64'd9); end
    WrEn0 = 1'b1; WrAddr0 = 5'd3; WrData0 = 64'h77;
    #1 Reset = 1'b0;
    #1;
    nvec++; if (rd0 !== 64'd0) begin nerr++; $display("FAIL mid_rd0: got %h expected %h", rd0, 64'd0); end
    nvec++; if (rd1 !== 64'd0) begin nerr++; $display("FAIL mid_rd1: got %h expected %h", rd1, 64'd0); end
    nvec++; if (DbgData !== 64'd0) begin nerr++; $display("FAIL mid_dbg: got %h expected %h", DbgData, 64'd0); end
    nvec++; if (Stall !== 1'b0) begin nerr++; $display("FAIL mid_stall: got %b expected 0", Stall); end
    @(posedge clk) #1;
    nvec++; if (rd0 !== 64'd0) begin nerr++; $display("FAIL mid_held: got %h expected %h", rd0, 64'd0); end
    @(negedge clk) idle();
    Reset = 1'b1;
    #1;
    nvec++; if (rd0 !== 64'd0) begin nerr++; $display("FAIL mid_write_lost: got %h expected %h", rd0, 64'd0); end
    nvec++; if (Stall !== 1'b0) begin nerr++; $display("FAIL mid_busy_lost: got %b expected 0", Stall); end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_dual_write();
    test_xzr();
    test_scoreboard();
    test_set_wins_dbg();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
